// File: rtl/ss_buf_arb.sv
// ss_buf_arb: round-robin arbiter sharing the write side of one single-datum
// handshake buffer among REQ_N requesters. Each grant issues exactly one
// buffer write, then a HOLD window masks the buffer's stale registered ready.
// Optional starvation timeout enabled by defining SS_BUF_ARB_TMO_EN.
module ss_buf_arb #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned REQ_N    = 4,
    parameter int unsigned HOLD_CYC = 2
`ifdef SS_BUF_ARB_TMO_EN
    ,
    parameter int unsigned TMO_CYC  = 1024
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [REQ_N-1:0]          req_i,
    input  logic [REQ_N*DATA_W-1:0]   data_i,
    output logic [REQ_N-1:0]          ack_o,
    output logic [$clog2(REQ_N)-1:0]  gnt_idx_o,
    output logic                      busy_o,
    output logic [DATA_W-1:0]         buf_wr_data_o,
    output logic                      buf_wr_o,
`ifdef SS_BUF_ARB_TMO_EN
    input  logic                      tmo_clr_i,
    output logic                      tmo_o,
`endif
    input  logic                      buf_rdy_i
);

    localparam int unsigned IDX_W  = $clog2(REQ_N);
    localparam int unsigned HCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e              state_q;
    logic [REQ_N-1:0]    ack_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic                busy_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                wr_q;
    logic [HCNT_W-1:0]   hold_cnt_q;

    logic [IDX_W-1:0]    gnt_idx_d;
    logic                gnt_vld_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic [IDX_W-1:0]    cand_idx;
    logic                grant;

    assign grant = (state_q == ST_IDLE) && (req_i != '0) && buf_rdy_i;

    // Round-robin search upward from the last grant, wrapping modulo REQ_N.
    always_comb begin
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = 1'b0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= REQ_N; i++) begin
            cand_idx = IDX_W'((32'(gnt_idx_q) + i) % REQ_N);
            if (!gnt_vld_d && req_i[cand_idx]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = cand_idx;
            end
        end
    end

    // Data mux for the selected winner.
    always_comb begin
        wr_data_d = '0;
        for (int unsigned k = 0; k < REQ_N; k++) begin
            if (IDX_W'(k) == gnt_idx_d) begin
                wr_data_d = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Sequencer: IDLE -> WR (one write strobe + ack) -> HOLD (mask stale ready).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            gnt_idx_q  <= IDX_W'(REQ_N - 1);
            busy_q     <= 1'b0;
            wr_data_q  <= '0;
            wr_q       <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant && gnt_vld_d) begin
                        state_q   <= ST_WR;
                        gnt_idx_q <= gnt_idx_d;
                        wr_data_q <= wr_data_d;
                        wr_q      <= 1'b1;
                        ack_q     <= REQ_N'(1) << gnt_idx_d;
                        busy_q    <= 1'b1;
                    end
                end
                ST_WR: begin
                    state_q    <= ST_HOLD;
                    wr_q       <= 1'b0;
                    ack_q      <= '0;
                    hold_cnt_q <= HCNT_W'(HOLD_CYC - 1);
                end
                ST_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wr_q    <= 1'b0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign gnt_idx_o     = gnt_idx_q;
    assign busy_o        = busy_q;
    assign buf_wr_data_o = wr_data_q;
    assign buf_wr_o      = wr_q;

`ifdef SS_BUF_ARB_TMO_EN
    localparam int unsigned TCNT_W = 16;

    logic [TCNT_W-1:0] tmo_cnt_q;
    logic              tmo_q;

    // Starvation counter: runs while requests wait on a not-ready buffer; clear wins over set.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if ((req_i == '0) || grant) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == ST_IDLE) && !buf_rdy_i &&
                         (tmo_cnt_q != TCNT_W'(TMO_CYC - 1))) begin
                tmo_cnt_q <= tmo_cnt_q + TCNT_W'(1);
            end
            if (tmo_clr_i) begin
                tmo_q <= 1'b0;
            end else if (tmo_cnt_q == TCNT_W'(TMO_CYC - 1)) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign tmo_o = tmo_q;
`endif

endmodule
